// File: rtl/irrig_pkg.sv
// Shared irrigation definitions: scheduler state encoding, zone count default
// and small helpers used by the scheduler and the per-zone FSMs.
package irrig_pkg;

   localparam int NZONES_DEFAULT = 4;
   localparam int ZONE_IDX_W     = 3;
   localparam int RUN_CNT_MAX    = 127;

   typedef enum logic [1:0] {
      SCH_IDLE  = 2'd0,
      SCH_PRIME = 2'd1,
      SCH_RUN   = 2'd2,
      SCH_DEAD  = 2'd3
   } sched_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/zone_scheduler_rr_arbiter.sv
// Round-robin zone picker: searches upward from the zone after last_grant,
// wrapping at N, and reports the first requesting zone.
module rr_arbiter
   import irrig_pkg::*;
#(
   parameter int N = NZONES_DEFAULT
) (
   input  logic [N-1:0]            req,
   input  logic [ZONE_IDX_W-1:0]   last_grant,
   output logic                    found,
   output logic [ZONE_IDX_W-1:0]   index
);

   logic [2*N-1:0] doubled;
   logic [N-1:0]   rotated;

   // Rotate the request vector so bit 0 is the zone just after last_grant
   always_comb begin
      doubled = {req, req};
      rotated = N'(doubled >> (int'(last_grant) + 1));
   end

   // Lowest set bit of the rotated vector is the next zone in round-robin order
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && rotated[i]) begin
            found = 1'b1;
            index = ZONE_IDX_W'((int'(last_grant) + 1 + i) % N);
         end
      end
   end

endmodule

// File: rtl/zone_scheduler.sv
// Irrigation zone scheduler: grants one valve at a time round-robin, primes the
// line before starting the pump, limits run slices and enforces a dead time
// with pump off and all valves closed between grants.
module zone_scheduler
   import irrig_pkg::*;
#(
   parameter int NZONES     = NZONES_DEFAULT,
   parameter int PRIME_TIME = 2,
   parameter int DEAD_TIME  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [NZONES-1:0]     req,
   input  logic [6:0]            max_run,
   output logic [NZONES-1:0]     valve,
   output logic                  pump,
   output logic [2:0]            grant_zone,
   output logic [1:0]            state,
   output logic                  slice_expired
);

   // Counter is shared by PRIME, RUN and DEAD, so it must cover both the
   // 127-cycle run saturation and the longest prime/dead interval.
   localparam int CW = max_int(7, $clog2(max_int(PRIME_TIME, DEAD_TIME) + 1));
   localparam logic [CW-1:0] PRIME_LAST = CW'(PRIME_TIME - 1);
   localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_TIME - 1);
   localparam logic [CW-1:0] RUN_SAT    = CW'(RUN_CNT_MAX);
   localparam logic [NZONES-1:0] ONE    = {{(NZONES-1){1'b0}}, 1'b1};

   sched_state_t        cur_state, next_state;
   logic [CW-1:0]       counter, next_counter;
   logic [NZONES-1:0]   next_valve;
   logic                next_pump;
   logic                next_expired;
   logic [2:0]          next_grant;
   logic [2:0]          last_grant, next_last;
   logic                arb_found;
   logic [2:0]          arb_index;
   logic                zone_req;
   logic                slice_hit;

   rr_arbiter #(.N(NZONES)) u_arbiter (
      .req        (req),
      .last_grant (last_grant),
      .found      (arb_found),
      .index      (arb_index)
   );

   assign state = cur_state;

   // Exit conditions: the granted zone's own request and the slice limit,
   // which uses >= so a lowered max_run takes effect at the next edge.
   always_comb begin
      zone_req  = |(req & (ONE << grant_zone));
      slice_hit = (max_run != 7'd0) && (counter >= (CW'(max_run) - CW'(1)));
   end

   // Next-state and next-output logic; everything drives registered outputs
   always_comb begin
      next_state   = cur_state;
      next_counter = counter;
      next_valve   = valve;
      next_pump    = pump;
      next_grant   = grant_zone;
      next_last    = last_grant;
      next_expired = 1'b0;
      case (cur_state)
         SCH_IDLE: begin
            next_valve = '0;
            next_pump  = 1'b0;
            if (enable && arb_found) begin
               next_valve   = ONE << arb_index;
               next_grant   = arb_index;
               next_last    = arb_index;
               next_counter = '0;
               next_state   = SCH_PRIME;
            end
         end
         SCH_PRIME: begin
            if (!enable || !zone_req) begin
               next_valve   = '0;
               next_pump    = 1'b0;
               next_counter = '0;
               next_state   = SCH_DEAD;
            end else if (counter == PRIME_LAST) begin
               next_pump    = 1'b1;
               next_counter = '0;
               next_state   = SCH_RUN;
            end else begin
               next_counter = counter + CW'(1);
            end
         end
         SCH_RUN: begin
            if (!enable || !zone_req || slice_hit) begin
               next_valve   = '0;
               next_pump    = 1'b0;
               next_counter = '0;
               next_expired = slice_hit && enable && zone_req;
               next_state   = SCH_DEAD;
            end else if (counter < RUN_SAT) begin
               next_counter = counter + CW'(1);
            end
         end
         SCH_DEAD: begin
            next_valve = '0;
            next_pump  = 1'b0;
            if (counter == DEAD_LAST) begin
               next_counter = '0;
               next_state   = SCH_IDLE;
            end else begin
               next_counter = counter + CW'(1);
            end
         end
         default: begin
            next_valve   = '0;
            next_pump    = 1'b0;
            next_counter = '0;
            next_state   = SCH_IDLE;
         end
      endcase
   end

   // State and output registers; reset closes valves and stops the pump at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state     <= SCH_IDLE;
         counter       <= '0;
         valve         <= '0;
         pump          <= 1'b0;
         slice_expired <= 1'b0;
         grant_zone    <= '0;
         last_grant    <= 3'(NZONES - 1);
      end else begin
         cur_state     <= next_state;
         counter       <= next_counter;
         valve         <= next_valve;
         pump          <= next_pump;
         slice_expired <= next_expired;
         grant_zone    <= next_grant;
         last_grant    <= next_last;
      end
   end

endmodule

// File: tb/tb_zone_scheduler.sv
// Directed self-checking bench for zone_scheduler with default parameters
// (4 zones, prime 2 cycles, dead 3 cycles). Outputs are sampled on the
// falling clock edge; inputs change just after it.
module tb_zone_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [3:0] req;
   logic [6:0] max_run;
   logic [3:0] valve;
   logic       pump;
   logic [2:0] grant_zone;
   logic [1:0] state;
   logic       slice_expired;

   int evaluated = 0;
   int failures  = 0;

   zone_scheduler #(.NZONES(4), .PRIME_TIME(2), .DEAD_TIME(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .req           (req),
      .max_run       (max_run),
      .valve         (valve),
      .pump          (pump),
      .grant_zone    (grant_zone),
      .state         (state),
      .slice_expired (slice_expired)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      evaluated++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [1:0] st, input logic [3:0] v,
                           input logic p, input logic [2:0] gz, input logic se);
      checkOutput({tag, ".state"}, 32'(state), 32'(st));
      checkOutput({tag, ".valve"}, 32'(valve), 32'(v));
      checkOutput({tag, ".pump"}, 32'(pump), 32'(p));
      checkOutput({tag, ".grant_zone"}, 32'(grant_zone), 32'(gz));
      checkOutput({tag, ".slice_expired"}, 32'(slice_expired), 32'(se));
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic en, input logic [6:0] mr);
      req     = r;
      enable  = en;
      max_run = mr;
   endtask

   task automatic stepCycle();
      @(negedge clk);
   endtask

   // Safety properties checked on every falling edge of the whole run
   always @(negedge clk) begin
      checkOutput("onehot0", 32'($onehot0(valve)), 32'd1);
      checkOutput("pump_only_in_run", 32'(!pump || (state == 2'd2)), 32'd1);
   end

   initial begin
      int         order [5];
      int         g;
      logic [3:0] oh;
      order = '{0, 1, 2, 3, 0};

      // Reset values
      rst_n = 1'b0;
      applyStimulus(4'b0000, 1'b0, 7'd0);
      stepCycle();
      stepCycle();
      checkAll("reset", 2'd0, 4'b0000, 1'b0, 3'd0, 1'b0);
      rst_n = 1'b1;

      // Single requester, unlimited run
      applyStimulus(4'b0001, 1'b1, 7'd0);
      stepCycle();
      checkAll("single.prime0", 2'd1, 4'b0001, 1'b0, 3'd0, 1'b0);
      stepCycle();
      checkAll("single.prime1", 2'd1, 4'b0001, 1'b0, 3'd0, 1'b0);
      for (int c = 0; c < 12; c++) begin
         stepCycle();
         checkAll($sformatf("single.run%0d", c), 2'd2, 4'b0001, 1'b1, 3'd0, 1'b0);
      end
      applyStimulus(4'b0000, 1'b1, 7'd0);
      stepCycle();
      checkAll("single.dead0", 2'd3, 4'b0000, 1'b0, 3'd0, 1'b0);
      stepCycle();
      checkAll("single.dead1", 2'd3, 4'b0000, 1'b0, 3'd0, 1'b0);
      stepCycle();
      checkAll("single.dead2", 2'd3, 4'b0000, 1'b0, 3'd0, 1'b0);
      stepCycle();
      checkAll("single.idle", 2'd0, 4'b0000, 1'b0, 3'd0, 1'b0);

      // Same lone requester is granted again after the dead time
      applyStimulus(4'b0001, 1'b1, 7'd0);
      stepCycle();
      checkAll("regrant.prime", 2'd1, 4'b0001, 1'b0, 3'd0, 1'b0);
      applyStimulus(4'b0000, 1'b1, 7'd0);
      stepCycle();
      checkAll("regrant.dead", 2'd3, 4'b0000, 1'b0, 3'd0, 1'b0);

      // Fresh reset, then all zones requesting with 5-cycle slices
      rst_n = 1'b0;
      stepCycle();
      rst_n = 1'b1;
      applyStimulus(4'b1111, 1'b1, 7'd5);
      for (int k = 0; k < 5; k++) begin
         g  = order[k];
         oh = 4'b0001 << g;
         stepCycle();
         checkAll($sformatf("rr%0d.prime0", k), 2'd1, oh, 1'b0, 3'(g), 1'b0);
         stepCycle();
         checkAll($sformatf("rr%0d.prime1", k), 2'd1, oh, 1'b0, 3'(g), 1'b0);
         for (int r = 0; r < 5; r++) begin
            stepCycle();
            checkAll($sformatf("rr%0d.run%0d", k, r), 2'd2, oh, 1'b1, 3'(g), 1'b0);
         end
         stepCycle();
         checkAll($sformatf("rr%0d.dead0", k), 2'd3, 4'b0000, 1'b0, 3'(g), 1'b1);
         stepCycle();
         checkAll($sformatf("rr%0d.dead1", k), 2'd3, 4'b0000, 1'b0, 3'(g), 1'b0);
         stepCycle();
         checkAll($sformatf("rr%0d.dead2", k), 2'd3, 4'b0000, 1'b0, 3'(g), 1'b0);
         stepCycle();
         checkAll($sformatf("rr%0d.idle", k), 2'd0, 4'b0000, 1'b0, 3'(g), 1'b0);
      end

      // Zone 2 drops its request during PRIME: pump never starts
      applyStimulus(4'b0100, 1'b1, 7'd5);
      stepCycle();
      checkAll("abort.prime", 2'd1, 4'b0100, 1'b0, 3'd2, 1'b0);
      applyStimulus(4'b0000, 1'b1, 7'd5);
      stepCycle();
      checkAll("abort.dead0", 2'd3, 4'b0000, 1'b0, 3'd2, 1'b0);
      stepCycle();
      checkAll("abort.dead1", 2'd3, 4'b0000, 1'b0, 3'd2, 1'b0);
      stepCycle();
      checkAll("abort.dead2", 2'd3, 4'b0000, 1'b0, 3'd2, 1'b0);
      stepCycle();
      checkAll("abort.idle", 2'd0, 4'b0000, 1'b0, 3'd2, 1'b0);

      // Enable dropped at counter 3 of a 5-cycle slice on zone 3
      applyStimulus(4'b1111, 1'b1, 7'd5);
      stepCycle();
      checkAll("endrop.prime0", 2'd1, 4'b1000, 1'b0, 3'd3, 1'b0);
      stepCycle();
      for (int r = 0; r < 4; r++) begin
         stepCycle();
         checkAll($sformatf("endrop.run%0d", r), 2'd2, 4'b1000, 1'b1, 3'd3, 1'b0);
      end
      applyStimulus(4'b1111, 1'b0, 7'd5);
      stepCycle();
      checkAll("endrop.dead0", 2'd3, 4'b0000, 1'b0, 3'd3, 1'b0);
      stepCycle();
      stepCycle();
      stepCycle();
      checkAll("endrop.idle", 2'd0, 4'b0000, 1'b0, 3'd3, 1'b0);
      for (int c = 0; c < 3; c++) begin
         stepCycle();
         checkAll($sformatf("endrop.hold%0d", c), 2'd0, 4'b0000, 1'b0, 3'd3, 1'b0);
      end

      // Lowering max_run below the running count expires at the next edge
      applyStimulus(4'b1111, 1'b1, 7'd0);
      stepCycle();
      checkAll("shrink.prime0", 2'd1, 4'b0001, 1'b0, 3'd0, 1'b0);
      stepCycle();
      for (int r = 0; r < 5; r++) begin
         stepCycle();
         checkAll($sformatf("shrink.run%0d", r), 2'd2, 4'b0001, 1'b1, 3'd0, 1'b0);
      end
      applyStimulus(4'b1111, 1'b1, 7'd2);
      stepCycle();
      checkAll("shrink.dead0", 2'd3, 4'b0000, 1'b0, 3'd0, 1'b1);
      stepCycle();
      stepCycle();
      stepCycle();
      checkAll("shrink.idle", 2'd0, 4'b0000, 1'b0, 3'd0, 1'b0);

      // Slice limit and request drop on the same edge: no expiry pulse
      stepCycle();
      checkAll("both.prime0", 2'd1, 4'b0010, 1'b0, 3'd1, 1'b0);
      stepCycle();
      stepCycle();
      checkAll("both.run0", 2'd2, 4'b0010, 1'b1, 3'd1, 1'b0);
      stepCycle();
      checkAll("both.run1", 2'd2, 4'b0010, 1'b1, 3'd1, 1'b0);
      applyStimulus(4'b1101, 1'b1, 7'd2);
      stepCycle();
      checkAll("both.dead0", 2'd3, 4'b0000, 1'b0, 3'd1, 1'b0);
      applyStimulus(4'b1111, 1'b1, 7'd0);
      stepCycle();
      stepCycle();
      stepCycle();
      checkAll("both.idle", 2'd0, 4'b0000, 1'b0, 3'd1, 1'b0);

      // Asynchronous reset in the middle of a run on zone 2
      stepCycle();
      checkAll("areset.prime0", 2'd1, 4'b0100, 1'b0, 3'd2, 1'b0);
      stepCycle();
      stepCycle();
      stepCycle();
      checkAll("areset.run1", 2'd2, 4'b0100, 1'b1, 3'd2, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkAll("areset.immediate", 2'd0, 4'b0000, 1'b0, 3'd0, 1'b0);
      stepCycle();
      checkAll("areset.held", 2'd0, 4'b0000, 1'b0, 3'd0, 1'b0);
      rst_n = 1'b1;
      stepCycle();
      checkAll("areset.first_grant", 2'd1, 4'b0001, 1'b0, 3'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
      $finish;
   end

endmodule
